// File: rtl/neuron_spi_reader_pkg.sv
// Shared definitions for the neuron readout path: FSM state encodings and the
// default chip geometry used by the readout FSM.
package neuron_spi_reader_pkg;

    localparam int DEFAULT_SPI_LENGTH = 384;
    localparam int DEFAULT_NUM_LANES  = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/spi_lane_shifter.sv
// Per-lane deserializer: shifts one bit in at the LSB per enable, so the first
// bit captured ends up in the MSB after WIDTH shifts.
module spi_lane_shifter #(
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // The shift register is cleared on reset so an aborted read leaves no residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (shift_en) begin
            q <= (q << 1) | WIDTH'(din);
        end
    end

endmodule

// File: rtl/neuron_spi_reader.sv
// Reads the chip's neuron output shift registers over NUM_LANES serial lanes:
// parallel-load strobe, BITS_PER_LANE clocked bits per lane, then publish.
module neuron_spi_reader
    import neuron_spi_reader_pkg::*;
#(
    parameter int SPI_LENGTH  = DEFAULT_SPI_LENGTH,
    parameter int NUM_LANES   = DEFAULT_NUM_LANES,
    parameter int CLK_DIV     = 2,
    parameter int LOAD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_read_trigger,
    input  logic [NUM_LANES-1:0]  spi_miso,
    output logic                  spi_clk,
    output logic                  spi_load,
    output logic                  spi_valid,
    output logic [SPI_LENGTH-1:0] spi_input,
    output logic                  idle
);

    localparam int BITS_PER_LANE = SPI_LENGTH / NUM_LANES;
    localparam int BIT_CNT_W     = $clog2(BITS_PER_LANE + 1);
    localparam int DIV_CNT_W     = $clog2(CLK_DIV + 1);
    localparam int LOAD_CNT_W    = $clog2(LOAD_CYCLES + 1);

    localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(BITS_PER_LANE - 1);
    localparam logic [DIV_CNT_W-1:0]  LAST_DIV  = DIV_CNT_W'(CLK_DIV - 1);
    localparam logic [LOAD_CNT_W-1:0] LAST_LOAD = LOAD_CNT_W'(LOAD_CYCLES - 1);

    if (SPI_LENGTH % NUM_LANES != 0) begin : g_length_check
        $error("SPI_LENGTH must be a multiple of NUM_LANES");
    end

    state_t                  state;
    state_t                  state_next;
    logic                    trig_q;
    logic                    armed;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [DIV_CNT_W-1:0]    div_cnt;
    logic [LOAD_CNT_W-1:0]   load_cnt;
    logic                    start;
    logic                    phase_end;
    logic                    load_end;
    logic                    shift_en;
    logic [SPI_LENGTH-1:0]   shift_data;

    // armed stays low until the trigger is seen low once, so a level held
    // through reset cannot masquerade as a fresh request.
    assign start     = (state == IDLE) && spi_read_trigger && !trig_q && armed;
    assign phase_end = (div_cnt == LAST_DIV);
    assign load_end  = (load_cnt == LAST_LOAD);
    assign shift_en  = (state == SHIFT_LO) && phase_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is defaulted before the case so no path leaves it unassigned.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start)     state_next = LOAD;
            LOAD:     if (load_end)  state_next = SHIFT_LO;
            SHIFT_LO: if (phase_end) state_next = SHIFT_HI;
            SHIFT_HI: if (phase_end) state_next = (bit_cnt == LAST_BIT) ? DONE : SHIFT_LO;
            DONE:                    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
        end else begin
            load_cnt <= (state == LOAD && !load_end) ? load_cnt + 1'b1 : '0;
            if ((state == SHIFT_LO || state == SHIFT_HI) && !phase_end) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (state == SHIFT_HI && phase_end) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Strobes are decoded from the next state and registered, so they line up
    // with the state they belong to and cannot glitch or overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q    <= 1'b0;
            armed     <= 1'b0;
            spi_clk   <= 1'b0;
            spi_load  <= 1'b0;
            idle      <= 1'b0;
            spi_valid <= 1'b0;
            spi_input <= '0;
        end else begin
            trig_q   <= spi_read_trigger;
            if (!spi_read_trigger) begin
                armed <= 1'b1;
            end
            spi_clk  <= (state_next == SHIFT_HI);
            spi_load <= (state_next == LOAD);
            idle     <= (state_next == IDLE);
            if (start) begin
                spi_valid <= 1'b0;
            end else if (state == DONE) begin
                spi_valid <= 1'b1;
                spi_input <= shift_data;
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        spi_lane_shifter #(
            .WIDTH(BITS_PER_LANE)
        ) u_shifter (
            .clk      (clk),
            .rst      (rst),
            .shift_en (shift_en),
            .din      (spi_miso[l]),
            .q        (shift_data[l*BITS_PER_LANE +: BITS_PER_LANE])
        );
    end

endmodule

// File: doc/neuron_spi_reader.md
NEURON_SPI_READER -- requirements
Module: neuron_spi_reader

Interface
REQ-001 SHALL have parameter SPI_LENGTH, default 384: width of the assembled neuron output vector.
REQ-002 SHALL have parameter NUM_LANES, default 4: number of parallel serial data lanes from the chip.
REQ-003 SHALL have parameter CLK_DIV, default 2: spi_clk half-period, in clk cycles (>=1).
REQ-004 SHALL have parameter LOAD_CYCLES, default 2: spi_load pulse width, in clk cycles (>=1).
REQ-005 SHALL derive BITS_PER_LANE = SPI_LENGTH/NUM_LANES; SPI_LENGTH SHALL be divisible by NUM_LANES.
REQ-006 clk  input  1  system clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 spi_read_trigger  input  1  read request from the readout FSM; level may stay high for several cycles.
REQ-009 spi_miso  input  NUM_LANES  serial data from the chip, one bit per lane.
REQ-010 spi_clk  output  1  shift clock to the chip.
REQ-011 spi_load  output  1  parallel-load strobe to the chip neuron shift registers.
REQ-012 spi_valid  output  1  level: spi_input holds a complete, stable read.
REQ-013 spi_input  output  SPI_LENGTH  assembled neuron output vector.
REQ-014 idle  output  1  high only in IDLE.

Function
REQ-015 SHALL implement states IDLE, LOAD, SHIFT_LO, SHIFT_HI and DONE.
REQ-016 A read SHALL start only on a trigger rising edge seen in IDLE (spi_read_trigger=1, previous-cycle value 0); IDLE SHALL go to LOAD on the next edge.
REQ-017 Rising edges in any state other than IDLE SHALL be ignored; a level held high from the ignored edge SHALL NOT start a read later.
REQ-018 spi_valid SHALL clear in the first cycle after the accepted edge, i.e. within 1 cycle, well inside the FSM's 4-cycle trigger pulse.
REQ-019 LOAD: spi_load=1 for exactly LOAD_CYCLES cycles, spi_clk=0, then go to SHIFT_LO.
REQ-020 SHIFT_LO: spi_clk=0 for CLK_DIV cycles; in its last cycle sample all spi_miso lanes; then go to SHIFT_HI.
REQ-021 SHIFT_HI: spi_clk=1 for CLK_DIV cycles; then go to SHIFT_LO, or to DONE after bit BITS_PER_LANE-1.
REQ-022 Bit mapping: the k-th sampled bit (k=0 first) of lane l SHALL land at spi_input[l*BITS_PER_LANE + BITS_PER_LANE-1-k] (MSB-first per lane).
REQ-023 DONE: one cycle; copy the shift registers to spi_input, set spi_valid=1, spi_clk=0, then go to IDLE.
REQ-024 spi_valid SHALL rise exactly LOAD_CYCLES + 2*CLK_DIV*BITS_PER_LANE + 2 cycles after the edge-detect cycle (388 at defaults).
REQ-025 spi_input and spi_valid SHALL hold until the next accepted trigger edge; spi_input SHALL NOT change during a read.
REQ-026 The bit counter SHALL be ceil(log2(BITS_PER_LANE+1)) bits wide and the divider counter ceil(log2(CLK_DIV+1)) bits wide; neither SHALL wrap within a read.
REQ-027 spi_clk and spi_load SHALL be registered outputs, glitch-free, and never high at the same time.

Reset
REQ-028 While rst=1: state=IDLE, spi_clk=0, spi_load=0, spi_valid=0, spi_input=0, idle=0, counters=0, shift registers=0, edge-detect register=0.
REQ-029 Reset asserted mid-read SHALL abort the read with no partial spi_input update.
REQ-030 idle SHALL go to 1 in the first cycle after rst deasserts.
REQ-031 A trigger held high through reset SHALL NOT start a read until it falls and rises again.

Structure
REQ-032 A shared package SHALL hold the state encodings (3-bit) and the default SPI_LENGTH/NUM_LANES constants used with the readout FSM.
REQ-033 The per-lane BITS_PER_LANE shift register SHALL be one sub-module, spi_lane_shifter (ports: clk, rst, shift_en, din, q), instantiated NUM_LANES times.

Verification
REQ-034 Lane model drives 0xA5 repeating MSB-first per lane; single 4-cycle trigger -> spi_valid after exactly 388 cycles, each lane's 96 bits = 0xA5 repeated.
REQ-035 Distinct per-lane patterns (lane0=all 1s, lane1=all 0s, lane2 alternating 1010..., lane3 = bit index[0]) -> bit placement matches REQ-022 exactly.
REQ-036 Second trigger while spi_valid=1 -> spi_valid low by the next cycle, prior spi_input held until DONE, new data at cycle 388.
REQ-037 Trigger edge at bit 40 of an active read -> ignored, one read only, spi_load pulses once.
REQ-038 rst asserted at bit 50 -> all outputs at reset values next cycle; trigger held high across reset does not start a read.
REQ-039 CLK_DIV=1, LOAD_CYCLES=1 -> spi_clk period 2 cycles, latency 1+192+2=195 cycles, data correct.
